// File: rtl/trig_prescale_sched.sv
// trig_prescale_sched
//   Multi-channel trigger scheduler that sits after a bank of per-channel
//   prescalers. Single-cycle prescaled pulses are latched per channel,
//   arbitrated round-robin onto one shared trigger output tagged with the
//   channel id, and separated by a programmable hold-off (dead time).
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   ch_pulse  per-channel prescaled trigger pulses
//   ch_en     per-channel enable mask (0 also clears the pending latch)
//   hold_len  hold-off length in cycles, captured at each grant
//   dout      scheduled trigger, one cycle wide
//   dout_id   granted channel id, held until the next grant
//   busy      high while in FIRE or HOLD
//   pend      pending-latch status
//
// Optional feature (macro TRIG_LOST_CNT_EN)
//   lost_clr  zeroes all lost-trigger counters (priority over increment)
//   lost_cnt  per-channel saturating lost-trigger counters,
//             channel i at [i*LCW +: LCW]
module trig_prescale_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned IDW = 2,
  parameter int unsigned DW  = 16,
  parameter int unsigned LCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ch_pulse,
  input  logic [NCH-1:0] ch_en,
  input  logic [DW-1:0]  hold_len,
  output logic           dout,
  output logic [IDW-1:0] dout_id,
  output logic           busy,
  output logic [NCH-1:0] pend
`ifdef TRIG_LOST_CNT_EN
  ,
  input  logic               lost_clr,
  output logic [NCH*LCW-1:0] lost_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           dout_q, dout_d;
  logic [IDW-1:0] dout_id_q, dout_id_d;
  logic           busy_q, busy_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [DW-1:0]  cnt_q, cnt_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic           grant;

  // Round-robin search as two priority passes: first the channels at or
  // above the rr pointer, then wrap around to the ones below it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!gnt_found && pend_q[i] && (i >= 32'(rr_q))) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!gnt_found && pend_q[i]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(i);
      end
    end
  end

  assign grant = (state_q == ST_IDLE) && gnt_found;

  // Pending latch: disable clears, a new pulse beats the grant clear.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!ch_en[i]) begin
        pend_d[i] = 1'b0;
      end else if (ch_pulse[i]) begin
        pend_d[i] = 1'b1;
      end else if (grant && (gnt_id == IDW'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dout_d    = 1'b0;
    dout_id_d = dout_id_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d   = ST_FIRE;
          dout_d    = 1'b1;
          dout_id_d = gnt_id;
          busy_d    = 1'b1;
          cnt_d     = hold_len;
          rr_d      = (gnt_id == IDW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
      ST_FIRE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dout_q    <= 1'b0;
      dout_id_q <= '0;
      busy_q    <= 1'b0;
      pend_q    <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      dout_id_q <= dout_id_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dout    = dout_q;
  assign dout_id = dout_id_q;
  assign busy    = busy_q;
  assign pend    = pend_q;

`ifdef TRIG_LOST_CNT_EN
  logic [NCH*LCW-1:0] lost_q, lost_d;

  // A pulse is lost when its channel is already pending and that pending
  // trigger is not the one being granted on this edge.
  always_comb begin
    lost_d = lost_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (lost_clr) begin
        lost_d[i*LCW +: LCW] = '0;
      end else if (ch_pulse[i] && ch_en[i] && pend_q[i] &&
                   !(grant && (gnt_id == IDW'(i))) &&
                   (lost_q[i*LCW +: LCW] != '1)) begin
        lost_d[i*LCW +: LCW] = lost_q[i*LCW +: LCW] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign lost_cnt = lost_q;
`else
  logic [LCW-1:0] unused_lcw;
  assign unused_lcw = '0;
`endif

endmodule

// File: tb/tb_trig_prescale_sched.sv
module tb_trig_prescale_sched;

`ifdef TRIG_LOST_CNT_EN
  localparam int unsigned TB_LCW = 4;
`else
  localparam int unsigned TB_LCW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_pulse = '0;
  logic [3:0]  ch_en = '0;
  logic [15:0] hold_len = '0;
  logic        dout;
  logic [1:0]  dout_id;
  logic        busy;
  logic [3:0]  pend;
`ifdef TRIG_LOST_CNT_EN
  logic                lost_clr = 1'b0;
  logic [4*TB_LCW-1:0] lost_cnt;
`endif

  trig_prescale_sched #(
    .NCH(4),
    .IDW(2),
    .DW (16),
    .LCW(TB_LCW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ch_pulse(ch_pulse),
    .ch_en   (ch_en),
    .hold_len(hold_len),
    .dout    (dout),
    .dout_id (dout_id),
    .busy    (busy),
    .pend    (pend)
`ifdef TRIG_LOST_CNT_EN
    ,
    .lost_clr(lost_clr),
    .lost_cnt(lost_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] id;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic push(input logic [1:0] id, input int c);
    exp_t e;
    e.id  = id;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every dout pulse must match the next expected grant.
  always @(negedge clk) begin
    if (dout === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_dout: id %0d at cycle %0d, none expected", dout_id, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout_id !== e.id || cyc != e.cyc) begin
          n_err++;
          $display("FAIL dout_grant: id %0d at cycle %0d, expected id %0d at cycle %0d",
                   dout_id, cyc, e.id, e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int d;

  initial begin
    // Reset state
    step();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_id", 32'(dout_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pend), 0);
    rst = 1'b0;
    ch_en = 4'b1111;
    hold_len = 16'd3;
    step();

    // Single trigger on ch2, hold 3 -> busy for 4 cycles
    d = cyc;
    ch_pulse = 4'b0100;
    push(2'd2, d + 2);
    step();
    ch_pulse = '0;
    chk("t1_pend", 32'(pend), 32'b0100);
    chk("t1_busy_pre", 32'(busy), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t1_busy", 32'(busy), 1);
      step();
    end
    chk("t1_busy_end", 32'(busy), 0);

    // Simultaneous ch0, ch1, ch3 from rr=0, hold 0
    do_reset();
    hold_len = '0;
    d = cyc;
    ch_pulse = 4'b1011;
    push(2'd0, d + 2);
    push(2'd1, d + 4);
    push(2'd3, d + 6);
    step();
    ch_pulse = '0;
    chk("t2_pend", 32'(pend), 32'b1011);
    repeat (6) step();
    chk("t2_pend_clr", 32'(pend), 0);
    chk("t2_idle", 32'(busy), 0);
    // rr wrapped to 0: ch0 is served before ch1
    d = cyc;
    ch_pulse = 4'b0011;
    push(2'd0, d + 2);
    push(2'd1, d + 4);
    step();
    ch_pulse = '0;
    repeat (4) step();

    // Fairness: ch0/ch1 every 2 cycles, rr starts at 2
    d = cyc;
    push(2'd0, d + 2);
    push(2'd1, d + 4);
    push(2'd0, d + 6);
    push(2'd1, d + 8);
    push(2'd0, d + 10);
    repeat (4) begin
      ch_pulse = 4'b0011;
      step();
      ch_pulse = '0;
      step();
    end
    repeat (3) step();
    chk("t3_pend_clr", 32'(pend), 0);

    // Masking: disabled ch0 never pends
    ch_en = 4'b1110;
    ch_pulse = 4'b0001;
    step();
    ch_pulse = '0;
    chk("t4_mask_pend", 32'(pend), 0);
    step();
    chk("t4_mask_busy", 32'(busy), 0);
    // ch3 pends during HOLD, then its enable drops
    ch_en = 4'b1111;
    hold_len = 16'd5;
    d = cyc;
    ch_pulse = 4'b0100;
    push(2'd2, d + 2);
    step();
    ch_pulse = '0;
    step();
    step();
    ch_pulse = 4'b1000;
    step();
    ch_pulse = '0;
    chk("t4_pend3", 32'(pend), 32'b1000);
    chk("t4_busy_hold", 32'(busy), 1);
    ch_en = 4'b0111;
    step();
    chk("t4_pend3_clr", 32'(pend), 0);
    repeat (8) step();
    ch_en = 4'b1111;
    repeat (3) step();

    // Reset during HOLD with pend=0110
    hold_len = 16'd10;
    d = cyc;
    ch_pulse = 4'b1000;
    push(2'd3, d + 2);
    step();
    ch_pulse = '0;
    step();
    step();
    ch_pulse = 4'b0110;
    step();
    ch_pulse = '0;
    chk("t5_pend", 32'(pend), 32'b0110);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_id", 32'(dout_id), 3);
    step();
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_dout", 32'(dout), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_pend", 32'(pend), 0);
    chk("t5_rst_id", 32'(dout_id), 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("t5_post_pend", 32'(pend), 0);
    chk("t5_post_busy", 32'(busy), 0);

    // Pulse on its own grant edge keeps the channel pending
    hold_len = '0;
    d = cyc;
    ch_pulse = 4'b0010;
    push(2'd1, d + 2);
    push(2'd1, d + 4);
    step();
    step();
    ch_pulse = '0;
    chk("t6_regrant_pend", 32'(pend), 32'b0010);
    step();
    step();
    chk("t6_pend_clr", 32'(pend), 0);

    // hold_len changes apply only at the next grant
    hold_len = 16'd1;
    d = cyc;
    ch_pulse = 4'b0001;
    push(2'd0, d + 2);
    step();
    ch_pulse = '0;
    step();
    hold_len = 16'd6;
    ch_pulse = 4'b0100;
    push(2'd2, d + 5);
    step();
    ch_pulse = '0;
    step();
    step();
    ch_pulse = 4'b1000;
    push(2'd3, d + 13);
    step();
    ch_pulse = '0;
    repeat (14) step();

`ifdef TRIG_LOST_CNT_EN
    // Two of three ch1 pulses during HOLD are lost
    hold_len = 16'd10;
    d = cyc;
    ch_pulse = 4'b0010;
    push(2'd1, d + 2);
    step();
    ch_pulse = '0;
    step();
    repeat (3) begin
      step();
      ch_pulse = 4'b0010;
      step();
      ch_pulse = '0;
    end
    push(2'd1, d + 14);
    chk("lc_ch1", 32'(lost_cnt[1*TB_LCW +: TB_LCW]), 2);
    chk("lc_ch0", 32'(lost_cnt[0 +: TB_LCW]), 0);
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    chk("lc_clr", 32'(lost_cnt[1*TB_LCW +: TB_LCW]), 0);
    repeat (25) step();
    // Saturation: 17 lost pulses on a 4-bit counter
    hold_len = 16'd100;
    d = cyc;
    ch_pulse = 4'b0010;
    push(2'd1, d + 2);
    step();
    ch_pulse = '0;
    step();
    step();
    ch_pulse = 4'b0010;
    repeat (18) step();
    ch_pulse = '0;
    push(2'd1, d + 104);
    chk("lc_sat", 32'(lost_cnt[1*TB_LCW +: TB_LCW]), 15);
    repeat (90) step();
`endif

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    step();
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
